// File: rtl/avm_arbiter_2m.sv
// Two-master / one-slave Avalon-MM arbiter with burst support and round-robin
// grant; the grant is held until the owner's whole burst has completed.
module avm_arbiter_2m #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BURST_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic [BURST_W-1:0]    m0_burstcount,
    input  logic                  m0_read,
    input  logic                  m0_write,
    output logic                  m0_waitrequest,
    output logic                  m0_readdatavalid,
    output logic [DATA_W-1:0]     m0_readdata,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic [BURST_W-1:0]    m1_burstcount,
    input  logic                  m1_read,
    input  logic                  m1_write,
    output logic                  m1_waitrequest,
    output logic                  m1_readdatavalid,
    output logic [DATA_W-1:0]     m1_readdata,

    output logic [ADDR_W-1:0]     s_address,
    output logic [DATA_W-1:0]     s_writedata,
    output logic [DATA_W/8-1:0]   s_byteenable,
    output logic [BURST_W-1:0]    s_burstcount,
    output logic                  s_read,
    output logic                  s_write,
    input  logic                  s_waitrequest,
    input  logic                  s_readdatavalid,
    input  logic [DATA_W-1:0]     s_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CMD      = 2'd1,
        ST_WR_BURST = 2'd2,
        ST_RD_DATA  = 2'd3
    } state_t;

    state_t               state_r;
    logic                 owner_r;
    logic                 prio_r;
    logic [BURST_W-1:0]   beats_r;

    logic                 req0_s;
    logic                 req1_s;
    logic                 own_read_s;
    logic                 own_write_s;
    logic [ADDR_W-1:0]    own_address_s;
    logic [DATA_W-1:0]    own_writedata_s;
    logic [DATA_W/8-1:0]  own_byteenable_s;
    logic [BURST_W-1:0]   own_burstcount_s;
    logic [BURST_W-1:0]   eff_count_s;
    logic                 wr_acc_s;
    logic                 rd_acc_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Read data is broadcast; only the valid strobe is steered to the owner
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    assign wr_acc_s = s_write & ~s_waitrequest;
    assign rd_acc_s = s_read  & ~s_waitrequest;

    // Multiplex the current owner's command fields
    always_comb begin
        if (owner_r) begin
            own_read_s       = m1_read;
            own_write_s      = m1_write;
            own_address_s    = m1_address;
            own_writedata_s  = m1_writedata;
            own_byteenable_s = m1_byteenable;
            own_burstcount_s = m1_burstcount;
        end else begin
            own_read_s       = m0_read;
            own_write_s      = m0_write;
            own_address_s    = m0_address;
            own_writedata_s  = m0_writedata;
            own_byteenable_s = m0_byteenable;
            own_burstcount_s = m0_burstcount;
        end
    end

    // A burstcount of zero behaves as a single beat
    always_comb begin
        if (own_burstcount_s == BURST_W'(0)) begin
            eff_count_s = BURST_W'(1);
        end else begin
            eff_count_s = own_burstcount_s;
        end
    end

    // Slave command and master handshake steering by state
    always_comb begin
        s_address        = '0;
        s_writedata      = '0;
        s_byteenable     = '0;
        s_burstcount     = '0;
        s_read           = 1'b0;
        s_write          = 1'b0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        case (state_r)
            ST_CMD, ST_WR_BURST: begin
                s_address    = own_address_s;
                s_writedata  = own_writedata_s;
                s_byteenable = own_byteenable_s;
                s_burstcount = own_burstcount_s;
                s_write      = own_write_s;
                // A simultaneous read+write from the owner resolves to the write
                if (state_r == ST_CMD) begin
                    s_read = own_read_s & ~own_write_s;
                end else begin
                    s_read = 1'b0;
                end
                if (owner_r) begin
                    m1_waitrequest = s_waitrequest;
                end else begin
                    m0_waitrequest = s_waitrequest;
                end
            end
            ST_RD_DATA: begin
                if (owner_r) begin
                    m1_readdatavalid = s_readdatavalid;
                end else begin
                    m0_readdatavalid = s_readdatavalid;
                end
            end
            default: begin
                s_read = 1'b0;
            end
        endcase
    end

    // Arbitration and burst tracking state machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            prio_r  <= 1'b0;
            beats_r <= BURST_W'(0);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req0_s | req1_s) begin
                        if (req0_s & req1_s) begin
                            owner_r <= prio_r;
                        end else begin
                            owner_r <= req1_s;
                        end
                        state_r <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (!own_read_s && !own_write_s) begin
                        state_r <= ST_IDLE;
                    end else if (wr_acc_s) begin
                        beats_r <= eff_count_s - BURST_W'(1);
                        if (eff_count_s == BURST_W'(1)) begin
                            state_r <= ST_IDLE;
                            prio_r  <= ~owner_r;
                        end else begin
                            state_r <= ST_WR_BURST;
                        end
                    end else if (rd_acc_s) begin
                        beats_r <= eff_count_s;
                        state_r <= ST_RD_DATA;
                    end
                end
                ST_WR_BURST: begin
                    if (wr_acc_s) begin
                        beats_r <= beats_r - BURST_W'(1);
                        if (beats_r == BURST_W'(1)) begin
                            state_r <= ST_IDLE;
                            prio_r  <= ~owner_r;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (s_readdatavalid) begin
                        beats_r <= beats_r - BURST_W'(1);
                        if (beats_r == BURST_W'(1)) begin
                            state_r <= ST_IDLE;
                            prio_r  <= ~owner_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
